// File: rtl/riscv_pkg.sv
// Shared decode definitions for the RISC-V decode stage: base opcodes, ALU operation
// classes, immediate formats and the control bundle carried through the ID/EX register.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;
  localparam logic [1:0] ALU_OP_IMM    = 2'b11;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  // Control bits that travel with an instruction from ID into EX.
  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       illegal;
  } id_ex_t;

endpackage

// File: rtl/riscv_imm_gen.sv
// Immediate generator: assembles the I/S/B/U/J immediate of a 32-bit instruction and
// sign-extends it from instr[31] to the datapath width.
module riscv_imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  imm_type_e       imm_type,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    // NOTE: a combinational block assigns a default first so every path drives the
    // signal and no latch is inferred.
    imm32 = '0;
    case (imm_type)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Every format already carries instr[31] in bit 31, so widening is a plain sign extension.
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/riscv_id_stage.sv
// Decode stage: decodes base opcodes, reads the regfile with WB bypass, stalls on load-use
// hazards and registers the result into a valid/ready ID/EX pipeline register.
module riscv_id_stage
  import riscv_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int REGFILE_COUNT = 32,
  parameter bit WB_BYPASS     = 1'b1,
  localparam int RW           = $clog2(REGFILE_COUNT)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] PC_ID_i,
  input  logic [31:0]     instr_ID_i,
  input  logic            flush_i,
  output logic [RW-1:0]   read_reg0_o,
  output logic [RW-1:0]   read_reg1_o,
  input  logic [XLEN-1:0] read_data0_i,
  input  logic [XLEN-1:0] read_data1_i,
  input  logic            wb_we_i,
  input  logic [RW-1:0]   wb_reg_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] PC_ID_o,
  output logic [XLEN-1:0] imm_o,
  output logic [XLEN-1:0] read_data0_o,
  output logic [XLEN-1:0] read_data1_o,
  output logic [RW-1:0]   write_reg_o,
  output logic [3:0]      alu_ctrl_o,
  output logic [1:0]      ALU_op_o,
  output logic            ALU_src_o,
  output logic            mem_to_reg_o,
  output logic            reg_write_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            branch_o,
  output logic            jump_o,
  output logic            illegal_o
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [RW-1:0]   rs1, rs2, rd;
  id_ex_t          ctrl;
  imm_type_e       imm_type;
  logic            uses_rs1, uses_rs2;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            load_use, advance;

  logic            valid_q;
  id_ex_t          ctrl_q;
  logic [XLEN-1:0] pc_q, imm_q, rd0_q, rd1_q;
  logic [RW-1:0]   rd_q;

  assign opcode = instr_ID_i[6:0];
  assign funct3 = instr_ID_i[14:12];
  assign rs1    = instr_ID_i[15 +: RW];
  assign rs2    = instr_ID_i[20 +: RW];
  assign rd     = instr_ID_i[7 +: RW];

  assign read_reg0_o = rs1;
  assign read_reg1_o = rs2;

  always_comb begin
    ctrl          = '0;
    ctrl.alu_ctrl = {1'b0, funct3};
    imm_type      = IMM_I;
    uses_rs1      = 1'b1;
    uses_rs2      = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.alu_op     = ALU_OP_ADD;
      end
      OPC_STORE: begin
        imm_type       = IMM_S;
        uses_rs2       = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      OPC_OP_IMM: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_OP_FUNCT;
        // Only the shift-right immediates use instr[30] to pick arithmetic vs logical.
        if (funct3 == 3'b101) ctrl.alu_ctrl[3] = instr_ID_i[30];
      end
      OPC_OP: begin
        uses_rs2         = 1'b1;
        ctrl.reg_write   = 1'b1;
        ctrl.alu_op      = ALU_OP_FUNCT;
        ctrl.alu_ctrl[3] = instr_ID_i[30];
      end
      OPC_BRANCH: begin
        imm_type    = IMM_B;
        uses_rs2    = 1'b1;
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_OP_BRANCH;
      end
      OPC_JAL: begin
        imm_type       = IMM_J;
        uses_rs1       = 1'b0;
        ctrl.jump      = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      OPC_JALR: begin
        ctrl.alu_src   = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      OPC_LUI: begin
        imm_type       = IMM_U;
        uses_rs1       = 1'b0;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_OP_IMM;
      end
      OPC_AUIPC: begin
        imm_type       = IMM_U;
        uses_rs1       = 1'b0;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      default: begin
        ctrl         = '0;
        ctrl.illegal = 1'b1;
      end
    endcase
  end

  riscv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr    (instr_ID_i),
    .imm_type (imm_type),
    .imm      (imm)
  );

  // x0 always reads zero; a same-cycle WB write to the source register wins over the regfile.
  function automatic logic [XLEN-1:0] bypass(input logic [RW-1:0]   rs,
                                             input logic [XLEN-1:0] rf_data);
    if (rs == '0)                                          return '0;
    if (WB_BYPASS && wb_we_i && wb_reg_i != '0 && wb_reg_i == rs) return wb_data_i;
    return rf_data;
  endfunction

  assign rs1_data = bypass(rs1, read_data0_i);
  assign rs2_data = bypass(rs2, read_data1_i);

  // The loaded value is not available until after EX/MEM, so a dependent instruction waits one cycle.
  assign load_use = valid_i && valid_q && ctrl_q.mem_read && (rd_q != '0) &&
                    ((uses_rs1 && rs1 == rd_q) || (uses_rs2 && rs2 == rd_q));
  assign advance  = !valid_q || ready_i;
  assign ready_o  = flush_i || (advance && !load_use);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    if (!rst_ni) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      pc_q    <= '0;
      imm_q   <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      rd_q    <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (advance) begin
      if (valid_i && !load_use) begin
        valid_q <= 1'b1;
        ctrl_q  <= ctrl;
        pc_q    <= PC_ID_i;
        imm_q   <= imm;
        rd0_q   <= rs1_data;
        rd1_q   <= rs2_data;
        rd_q    <= rd;
      end else begin
        valid_q <= 1'b0;
        ctrl_q  <= '0;
      end
    end
  end

  assign valid_o      = valid_q;
  assign PC_ID_o      = pc_q;
  assign imm_o        = imm_q;
  assign read_data0_o = rd0_q;
  assign read_data1_o = rd1_q;
  assign write_reg_o  = rd_q;
  assign alu_ctrl_o   = ctrl_q.alu_ctrl;
  assign ALU_op_o     = ctrl_q.alu_op;
  assign ALU_src_o    = ctrl_q.alu_src;
  assign mem_to_reg_o = ctrl_q.mem_to_reg;
  assign reg_write_o  = ctrl_q.reg_write;
  assign mem_read_o   = ctrl_q.mem_read;
  assign mem_write_o  = ctrl_q.mem_write;
  assign branch_o     = ctrl_q.branch;
  assign jump_o       = ctrl_q.jump;
  assign illegal_o    = ctrl_q.illegal;

endmodule
